inv_cipher: RTL and testbench

INV_CIPHER -- requirements
Module: inv_cipher

---
 rtl/inv_cipher_pkg.sv | 33 +++
 rtl/inv_cipher_inv_mix_columns.sv | 33 +++
 rtl/inv_cipher.sv | 102 ++++++++++
 tb/tb_inv_cipher.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/inv_cipher_pkg.sv
// Shared definitions for the AES-128 inverse cipher: FSM encodings, round count,
// the inverse S-box and the GF(2^8) doubling helper.
package inv_cipher_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    ROUND = 3'b010,
    DONE  = 3'b011
  } fsm_e;

  localparam logic [3:0] NUM_ROUNDS = 4'd10;

  // Entry 0 sits in the top byte, so a byte b is found at index ~b (255 - b).
  localparam logic [255:0][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[~b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/inv_cipher_inv_mix_columns.sv
// Combinational InvMixColumns over four state columns, byte 0 of a column in the top byte.
module inv_mix_columns
  import inv_cipher_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [3:0][DATA_WIDTH-1:0] state,
  output logic [3:0][DATA_WIDTH-1:0] mixed
);

  function automatic logic [7:0] mul(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (k[3] ? x8 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^ (k[1] ? x2 : 8'h00) ^ (k[0] ? a : 8'h00);
  endfunction

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign a0 = state[c][31:24];
    assign a1 = state[c][23:16];
    assign a2 = state[c][15:8];
    assign a3 = state[c][7:0];
    assign mixed[c] = {
      mul(a0, 4'hE) ^ mul(a1, 4'hB) ^ mul(a2, 4'hD) ^ mul(a3, 4'h9),
      mul(a0, 4'h9) ^ mul(a1, 4'hE) ^ mul(a2, 4'hB) ^ mul(a3, 4'hD),
      mul(a0, 4'hD) ^ mul(a1, 4'h9) ^ mul(a2, 4'hE) ^ mul(a3, 4'hB),
      mul(a0, 4'hB) ^ mul(a1, 4'hD) ^ mul(a2, 4'h9) ^ mul(a3, 4'hE)
    };
  end

endmodule

// File: rtl/inv_cipher.sv
// Iterative AES-128 inverse cipher: one round per clock, round keys fetched by index
// from an external key store, plaintext flagged by a one-cycle valid pulse.
module inv_cipher
  import inv_cipher_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_in,
  input  logic [DATA_WIDTH-1:0] text_0_in,
  input  logic [DATA_WIDTH-1:0] text_1_in,
  input  logic [DATA_WIDTH-1:0] text_2_in,
  input  logic [DATA_WIDTH-1:0] text_3_in,
  input  logic [DATA_WIDTH-1:0] key_0_in,
  input  logic [DATA_WIDTH-1:0] key_1_in,
  input  logic [DATA_WIDTH-1:0] key_2_in,
  input  logic [DATA_WIDTH-1:0] key_3_in,
  output logic [3:0]            round_key_idx_out,
  output logic [DATA_WIDTH-1:0] text_0_out,
  output logic [DATA_WIDTH-1:0] text_1_out,
  output logic [DATA_WIDTH-1:0] text_2_out,
  output logic [DATA_WIDTH-1:0] text_3_out,
  output logic                  busy_out,
  output logic                  plain_dv_flag
);

  fsm_e                         fsm_r;
  logic [3:0]                   count_r;
  logic [3:0][DATA_WIDTH-1:0]   state_r;
  logic [3:0][DATA_WIDTH-1:0]   text_w, key_w, sub_bytes, added, mixed, round_next;

  assign text_w = {text_3_in, text_2_in, text_1_in, text_0_in};
  assign key_w  = {key_3_in, key_2_in, key_1_in, key_0_in};

  // InvShiftRows folded into the S-box lookup: row r of column c comes from column c-r.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sub_bytes[c][DATA_WIDTH-1-8*r -: 8] =
        inv_sbox(state_r[(c + 4 - r) % 4][DATA_WIDTH-1-8*r -: 8]);
    end
  end

  assign added = sub_bytes ^ key_w;

  inv_mix_columns #(.DATA_WIDTH(DATA_WIDTH)) u_inv_mix_columns (
    .state (added),
    .mixed (mixed)
  );

  always_comb begin
    round_next = mixed;
    if (count_r == 4'd0)
      round_next = state_r ^ key_w;
    else if (count_r == NUM_ROUNDS)
      round_next = added;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_r             <= IDLE;
      count_r           <= 4'd0;
      state_r           <= '0;
      busy_out          <= 1'b0;
      plain_dv_flag     <= 1'b0;
      round_key_idx_out <= NUM_ROUNDS;
    end else begin
      plain_dv_flag <= 1'b0;
      case (fsm_r)
        IDLE: begin
          if (start_in) begin
            state_r           <= text_w;
            count_r           <= 4'd0;
            busy_out          <= 1'b1;
            round_key_idx_out <= NUM_ROUNDS;
            fsm_r             <= ROUND;
          end
        end
        ROUND: begin
          state_r <= round_next;
          if (count_r == NUM_ROUNDS) begin
            busy_out          <= 1'b0;
            plain_dv_flag     <= 1'b1;
            round_key_idx_out <= NUM_ROUNDS;
            fsm_r             <= DONE;
          end else begin
            count_r           <= count_r + 4'd1;
            round_key_idx_out <= NUM_ROUNDS - count_r - 4'd1;
          end
        end
        DONE:    fsm_r <= IDLE;
        default: fsm_r <= IDLE;
      endcase
    end
  end

  assign text_0_out = state_r[0];
  assign text_1_out = state_r[1];
  assign text_2_out = state_r[2];
  assign text_3_out = state_r[3];

endmodule

// File: tb/tb_inv_cipher.sv
// Bench for inv_cipher: known FIPS-197 vectors plus random blocks produced by a
// forward AES-128 model, with timing, start-ignore and mid-operation reset scenarios.
module tb_inv_cipher;

  logic         clk = 1'b0;
  logic         rst_n, start;
  logic [127:0] ct_in;
  logic [127:0] key_sel;
  logic [31:0]  key_0, key_1, key_2, key_3;
  logic [31:0]  t0, t1, t2, t3;
  logic [3:0]   idx;
  logic         busy, dv;
  logic [127:0] text_out;

  logic [7:0]   sbox [256];
  logic [127:0] rk [11];
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  inv_cipher #(.DATA_WIDTH(32)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start_in          (start),
    .text_0_in         (ct_in[127:96]),
    .text_1_in         (ct_in[95:64]),
    .text_2_in         (ct_in[63:32]),
    .text_3_in         (ct_in[31:0]),
    .key_0_in          (key_0),
    .key_1_in          (key_1),
    .key_2_in          (key_2),
    .key_3_in          (key_3),
    .round_key_idx_out (idx),
    .text_0_out        (t0),
    .text_1_out        (t1),
    .text_2_out        (t2),
    .text_3_out        (t3),
    .busy_out          (busy),
    .plain_dv_flag     (dv)
  );

  assign text_out = {t0, t1, t2, t3};

  // External key store: answers whatever round index the DUT asks for.
  always_comb begin
    key_sel = '0;
    if (idx <= 4'd10) key_sel = rk[idx];
  end
  assign key_0 = key_sel[127:96];
  assign key_1 = key_sel[95:64];
  assign key_2 = key_sel[63:32];
  assign key_3 = key_sel[31:0];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  // S-box from first principles: multiplicative inverse then the affine map.
  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
          ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox[x] = s;
    end
  endtask

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] res;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk[0][127-8*i -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+r)%4)+r];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++)
            s[4*c+r] = gmul(t[4*c+r], 8'h02) ^ gmul(t[4*c+(r+1)%4], 8'h03)
                       ^ t[4*c+(r+2)%4] ^ t[4*c+(r+3)%4];
      end else begin
        s = t;
      end
      for (int i = 0; i < 16; i++) s[i] ^= rk[rnd][127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  task automatic run_op(input string tag, input logic [127:0] ct, input logic [127:0] pt,
                        input bit poke);
    @(negedge clk);
    ct_in = ct;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 11; i++) begin
      chk({tag, "_busy"}, 128'(busy), 128'(1));
      chk({tag, "_idx"}, 128'(idx), 128'(10 - i));
      chk({tag, "_dv_early"}, 128'(dv), 128'(0));
      if (poke) begin
        start = 1'($urandom_range(0, 1));
        ct_in = {$urandom, $urandom, $urandom, $urandom};
      end
      @(negedge clk);
    end
    chk({tag, "_dv"}, 128'(dv), 128'(1));
    chk({tag, "_busy_done"}, 128'(busy), 128'(0));
    chk({tag, "_plain"}, text_out, pt);
    chk({tag, "_idx_done"}, 128'(idx), 128'(10));
    if (poke) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_dv_off"}, 128'(dv), 128'(0));
    chk({tag, "_hold"}, text_out, pt);
    @(negedge clk);
    chk({tag, "_no_retrig"}, 128'(busy), 128'(0));
    chk({tag, "_hold2"}, text_out, pt);
  endtask

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  initial begin
    logic [127:0] key, pt_a, pt_b, ct_a, ct_b;
    start = 1'b0;
    ct_in = '0;
    rst_n = 1'b1;
    build_sbox();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_text", text_out, 128'(0));
    chk("rst_idx", 128'(idx), 128'(10));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_dv", 128'(dv), 128'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    expand(C1_KEY);
    run_op("c1", C1_CT, C1_PT, 1'b0);
    expand(B_KEY);
    run_op("appb", B_CT, B_PT, 1'b0);

    for (int n = 0; n < 3; n++) begin
      key  = {$urandom, $urandom, $urandom, $urandom};
      pt_a = {$urandom, $urandom, $urandom, $urandom};
      expand(key);
      run_op(n == 1 ? "rand_poke" : "rand", encrypt(pt_a), pt_a, n == 1);
    end

    // Reset in the middle of a C.1 decryption, at round count 5.
    expand(C1_KEY);
    @(negedge clk);
    ct_in = C1_CT;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_idx5", 128'(idx), 128'(5));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_text", text_out, 128'(0));
    chk("mid_rst_idx", 128'(idx), 128'(10));
    chk("mid_rst_busy", 128'(busy), 128'(0));
    chk("mid_rst_dv", 128'(dv), 128'(0));
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("mid_rst_nodv", 128'(dv), 128'(0));
      if (i == 3) rst_n = 1'b1;
    end
    run_op("c1_after_rst", C1_CT, C1_PT, 1'b0);

    // start held high: operations back to back, 13 cycles apart.
    key  = {$urandom, $urandom, $urandom, $urandom};
    pt_a = {$urandom, $urandom, $urandom, $urandom};
    pt_b = {$urandom, $urandom, $urandom, $urandom};
    expand(key);
    ct_a = encrypt(pt_a);
    ct_b = encrypt(pt_b);
    @(negedge clk);
    ct_in = ct_a;
    start = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 1) ct_in = ct_b;
      chk("b2b_dv", 128'(dv), 128'((c == 12 || c == 25) ? 1 : 0));
      chk("b2b_busy", 128'(busy), 128'(((c >= 1 && c <= 11) || (c >= 14 && c <= 24)) ? 1 : 0));
      if (c == 12) chk("b2b_plain_a", text_out, pt_a);
      if (c == 25) begin
        chk("b2b_plain_b", text_out, pt_b);
        start = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
